// File: rtl/dds_spi_pkg.sv
// dds_spi_pkg: shared FSM state type, frame widths and address helper
package dds_spi_pkg;
    typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;
    localparam int INSTR_W  = 8;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int READ_BIT = 7;
    function automatic logic in_range(input logic [ADDR_W-1:0] a, input int n);
        return int'(a) < n;
    endfunction
endpackage

// File: rtl/dds_spi_responder_sync.sv
// spi_sync_edge: N-stage synchronizer with registered rise/fall pulses
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic prev_q, rise_q, fall_q;
    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    // resynchronize the pin and flag level changes one cycle after they appear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= STAGES'({sync_q, d_i});
            prev_q <= level_o;
            rise_q <= level_o & ~prev_q;
            fall_q <= ~level_o & prev_q;
        end
    end
endmodule

// File: rtl/dds_spi_responder.sv
// dds_spi_responder: DDS serial-port slave with buffered/active register banks (readback under DDS_RSP_READBACK_EN)
module dds_spi_responder
    import dds_spi_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              sdio,
    input  logic              syncio,
    input  logic              io_update,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic [ADDR_W-1:0] act_addr,
    output logic [DATA_W-1:0] act_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              upd_pulse,
    output logic              frame_err
);
    logic cs_lvl, sdio_lvl, syncio_lvl, sclk_rise, sclk_fall, upd_rise;
    logic [8:0] unused_sync;
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (.clk(clk), .rst(rst), .d_i(cs),
        .level_o(cs_lvl), .rise_o(unused_sync[0]), .fall_o(unused_sync[1]));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sdio (.clk(clk), .rst(rst), .d_i(sdio),
        .level_o(sdio_lvl), .rise_o(unused_sync[2]), .fall_o(unused_sync[3]));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_syncio (.clk(clk), .rst(rst), .d_i(syncio),
        .level_o(syncio_lvl), .rise_o(unused_sync[4]), .fall_o(unused_sync[5]));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst(rst), .d_i(sclk),
        .level_o(unused_sync[6]), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_upd (.clk(clk), .rst(rst), .d_i(io_update),
        .level_o(unused_sync[7]), .rise_o(upd_rise), .fall_o(unused_sync[8]));

    state_t state_q;
    logic [5:0] cnt_q;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-2:0] shift_q;
    logic [DATA_W-1:0] data_d, act_data_q, wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic wr_valid_q, frame_err_q, upd_pulse_q;
    logic [DATA_W-1:0] buffer_q [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic abort, instr_last, data_last, commit;

    // cs high or syncio high kills the frame regardless of state
    assign abort      = cs_lvl | syncio_lvl;
    assign instr_d    = {instr_q[INSTR_W-2:0], sdio_lvl};
    assign data_d     = {shift_q, sdio_lvl};
    assign instr_last = state_q == INSTR && sclk_rise && cnt_q == 6'd7 && !abort;
    assign data_last  = state_q == DATA && sclk_rise && cnt_q == 6'd39 && !abort;
    assign commit     = data_last && !instr_q[READ_BIT] && in_range(instr_q[ADDR_W-1:0], NUM_REGS);

    // frame FSM: shifts instruction and data, reports commits and aborted frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            instr_q     <= '0;
            shift_q     <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_valid_q  <= commit;
            frame_err_q <= 1'b0;
            if (abort) begin
                frame_err_q <= (state_q == INSTR || state_q == DATA) && cnt_q != 6'd0;
                state_q     <= IDLE;
                cnt_q       <= '0;
                instr_q     <= '0;
                shift_q     <= '0;
            end else begin
                case (state_q)
                    IDLE:  state_q <= INSTR;
                    INSTR: if (sclk_rise) begin
                        instr_q <= instr_d;
                        cnt_q   <= cnt_q + 6'd1;
                        if (cnt_q == 6'd7) state_q <= DATA;
                    end
                    DATA:  if (sclk_rise) begin
                        shift_q <= data_d[DATA_W-2:0];
                        cnt_q   <= cnt_q + 6'd1;
                        if (cnt_q == 6'd39) state_q <= DONE;
                    end
                    default: ;
                endcase
            end
            if (commit) begin
                wr_addr_q <= instr_q[ADDR_W-1:0];
                wr_data_q <= data_d;
            end
        end
    end

    // buffer bank takes committed writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) buffer_q[i] <= '0;
        end else if (commit) begin
            buffer_q[instr_q[ADDR_W-1:0]] <= data_d;
        end
    end

    // active bank copies the pre-commit buffer on an io_update edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) active_q[i] <= '0;
            upd_pulse_q <= 1'b0;
        end else begin
            if (upd_rise) active_q <= buffer_q;
            upd_pulse_q <= upd_rise;
        end
    end

    // local read port into the active bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) act_data_q <= '0;
        else act_data_q <= in_range(act_addr, NUM_REGS) ? active_q[act_addr] : '0;
    end

`ifdef DDS_RSP_READBACK_EN
    logic [DATA_W-1:0] out_sh_q, rd_word;
    logic sdo_q, sdo_oe_q;
    assign rd_word = in_range(instr_d[ADDR_W-1:0], NUM_REGS) ? active_q[instr_d[ADDR_W-1:0]] : '0;
    // read shifter: loaded on the last instruction edge, one bit per falling edge while in DATA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sh_q <= '0;
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
        end else if (instr_last && instr_d[READ_BIT]) begin
            out_sh_q <= rd_word;
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
        end else if (state_q == DATA && instr_q[READ_BIT] && !abort && !data_last) begin
            if (sclk_fall) begin
                sdo_q    <= out_sh_q[DATA_W-1];
                out_sh_q <= {out_sh_q[DATA_W-2:0], 1'b0};
                sdo_oe_q <= 1'b1;
            end
        end else begin
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
        end
    end
    assign sdo    = sdo_q;
    assign sdo_oe = sdo_oe_q;
`else
    logic unused_rd;
    assign unused_rd = sclk_fall ^ instr_last;
    assign sdo    = 1'b0;
    assign sdo_oe = 1'b0;
`endif

    assign act_data  = act_data_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign upd_pulse = upd_pulse_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_dds_spi_responder.sv
// tb_dds_spi_responder: directed frames against dds_spi_responder with immediate-assertion checks
module tb_dds_spi_responder;
    logic clk = 0, rst = 1, cs = 1, sclk = 0, sdio = 0, syncio = 0, io_update = 0;
    logic [4:0] act_addr = 0;
    logic sdo, sdo_oe, wr_valid, upd_pulse, frame_err;
    logic [4:0] wr_addr;
    logic [31:0] act_data, wr_data, rd;
    int checks = 0, errors = 0;
    int wr_cnt = 0, upd_cnt = 0, err_cnt = 0, both_cnt = 0;
    int oe_n, w0, u0, e0;

    dds_spi_responder dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .sdio(sdio), .syncio(syncio),
        .io_update(io_update), .sdo(sdo), .sdo_oe(sdo_oe), .act_addr(act_addr),
        .act_data(act_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .upd_pulse(upd_pulse), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) wr_cnt++;
        if (upd_pulse) upd_cnt++;
        if (frame_err) err_cnt++;
        if (wr_valid && upd_pulse) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive nbits of a frame MSB-first; data-phase sdo is sampled just before each rising edge
    task automatic frame(input logic [39:0] f, input int nbits, input bit upd_last,
                         output logic [31:0] r, output int oe);
        r = 0;
        oe = 0;
        cs = 0;
        #60;
        for (int i = 0; i < nbits; i++) begin
            sdio = f[39-i];
            #60;
            if (i >= 8) begin
                r = {r[30:0], sdo};
                if (sdo_oe) oe++;
            end
            if (upd_last && i == 39) io_update = 1;
            sclk = 1;
            #60;
            sclk = 0;
        end
    endtask

    task automatic finish_frame();
        #60;
        cs = 1;
        io_update = 0;
        #120;
    endtask

    task automatic pulse_update();
        io_update = 1;
        #100;
        io_update = 0;
        #100;
    endtask

    task automatic check_act(input string tag, input logic [4:0] a, input logic [31:0] exp);
        act_addr = a;
        #30;
        chk(tag, act_data, exp);
    endtask

    initial begin
        #50;
        chk("rst_sdo", {31'd0, sdo}, 0);
        chk("rst_sdo_oe", {31'd0, sdo_oe}, 0);
        chk("rst_wr_valid", {31'd0, wr_valid}, 0);
        chk("rst_wr_addr", {27'd0, wr_addr}, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_upd", {31'd0, upd_pulse}, 0);
        chk("rst_err", {31'd0, frame_err}, 0);
        chk("rst_act", act_data, 0);
        rst = 0;
        #100;

        w0 = wr_cnt;
        frame({8'h0E, 32'h12345678}, 40, 0, rd, oe_n);
        finish_frame();
        chk("wr1_count", wr_cnt - w0, 1);
        chk("wr1_addr", {27'd0, wr_addr}, 32'h0E);
        chk("wr1_data", wr_data, 32'h12345678);
        check_act("wr1_act_before_upd", 5'h0E, 0);
        u0 = upd_cnt;
        pulse_update();
        chk("upd1_count", upd_cnt - u0, 1);
        check_act("wr1_act_after_upd", 5'h0E, 32'h12345678);

        w0 = wr_cnt;
        frame({8'h8E, 32'hFFFFFFFF}, 40, 0, rd, oe_n);
        finish_frame();
`ifdef DDS_RSP_READBACK_EN
        chk("rd_data", rd, 32'h12345678);
        chk("rd_oe_bits", oe_n, 32);
`else
        chk("rd_data_off", rd, 0);
        chk("rd_oe_bits_off", oe_n, 0);
`endif
        chk("rd_oe_after", {31'd0, sdo_oe}, 0);
        chk("rd_no_write", wr_cnt - w0, 0);
        chk("rd_wr_data_kept", wr_data, 32'h12345678);

        w0 = wr_cnt;
        e0 = err_cnt;
        frame({8'h01, 32'hDEADBEEF}, 20, 0, rd, oe_n);
        finish_frame();
        chk("abort_err", err_cnt - e0, 1);
        chk("abort_no_write", wr_cnt - w0, 0);
        pulse_update();
        check_act("abort_buf_clean", 5'h01, 0);

        e0 = err_cnt;
        frame({8'h02, 32'hA5A5A5A5}, 12, 0, rd, oe_n);
        syncio = 1;
        #100;
        syncio = 0;
        cs = 1;
        #120;
        w0 = wr_cnt;
        frame({8'h02, 32'hA5A5A5A5}, 40, 0, rd, oe_n);
        finish_frame();
        chk("sync_err", err_cnt - e0, 1);
        chk("sync_write", wr_cnt - w0, 1);
        chk("sync_wr_data", wr_data, 32'hA5A5A5A5);
        pulse_update();
        check_act("sync_act", 5'h02, 32'hA5A5A5A5);

        u0 = both_cnt;
        frame({8'h03, 32'h55AA55AA}, 40, 1, rd, oe_n);
        finish_frame();
        chk("coll_same_cycle", both_cnt - u0, 1);
        check_act("coll_act_old", 5'h03, 0);
        pulse_update();
        check_act("coll_act_new", 5'h03, 32'h55AA55AA);

        e0 = err_cnt;
        frame({8'h04, 32'h0BADF00D}, 30, 0, rd, oe_n);
        rst = 1;
        #30;
        chk("mrst_wr_addr", {27'd0, wr_addr}, 0);
        chk("mrst_wr_data", wr_data, 0);
        chk("mrst_act", act_data, 0);
        chk("mrst_wr_valid", {31'd0, wr_valid}, 0);
        cs = 1;
        #30;
        rst = 0;
        #100;
        check_act("mrst_active_clear", 5'h0E, 0);
        pulse_update();
        check_act("mrst_buffer_clear", 5'h02, 0);
        chk("mrst_no_err", err_cnt - e0, 0);
        w0 = wr_cnt;
        frame({8'h05, 32'hCAFEF00D}, 40, 0, rd, oe_n);
        finish_frame();
        chk("post_rst_write", wr_cnt - w0, 1);
        chk("post_rst_addr", {27'd0, wr_addr}, 32'h05);
        pulse_update();
        check_act("post_rst_act", 5'h05, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dds_spi_responder.md
# dds_spi_responder

Synthesizable responder for the DDS 3-wire/4-wire serial control port: the slave end of the link that the serial write-command master drives (CS, SCLK, SDIO, SDO, SYNCIO, IO_UPDATE). It decodes 40-bit frames (8-bit instruction, 32-bit data) into a buffered register bank and transfers buffered values to an active bank on IO_UPDATE. Active registers can be read back serially on SDO. It is used as an on-board loopback target and in system benches, in place of the physical DDS.

## Interface
- NUM_REGS, 32: number of 32-bit registers; address width is 5.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers.
- clk  in  1  system clock; SCLK must be no faster than clk/8.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  chip select, active low.
- sclk  in  1  serial clock, mode 0 (idle low, master samples on rising edge).
- sdio  in  1  serial data from master.
- syncio  in  1  high aborts the current frame and clears the serial state.
- io_update  in  1  rising edge copies buffer bank to active bank.
- sdo  out  1  serial read data.
- sdo_oe  out  1  high while read data is being driven.
- act_addr  in  5  local read address into the active bank.
- act_data  out  32  active[act_addr], registered, 1-cycle latency.
- wr_valid  out  1  1-cycle pulse when a write frame commits to the buffer bank.
- wr_addr  out  5  address of the last committed write.
- wr_data  out  32  data of the last committed write.
- upd_pulse  out  1  1-cycle pulse when the buffer-to-active copy executes.
- frame_err  out  1  1-cycle pulse when CS rises or SYNCIO asserts mid-frame.

## Operation
- Inputs cs, sclk, sdio, syncio and io_update pass through SYNC_STAGES synchronizers. Rising- and falling-edge detectors act on the synchronized sclk and io_update.
- Instruction byte, MSB first:
  - bit7 = 1 is a read; 0 is a write.
  - bits6:5 are ignored.
  - bits4:0 are the address.
  - An address ≥ NUM_REGS is accepted, but the write or read is discarded (read returns 0).
- FSM states:
  - IDLE → INSTR when cs falls.
  - INSTR → DATA after the 8th sclk rising edge.
  - DATA → DONE after the 32nd data rising edge.
  - DONE → IDLE when cs rises.
  - From any state, cs high or syncio high forces IDLE and clears the bit counter and shift registers.
  - Any rising sclk edges received in DONE are ignored.
- Write frames: on the 32nd data bit the shift register commits to buffer[addr]. wr_addr and wr_data update, and wr_valid pulses.
- Read frames: on the 8th instruction edge, active[addr] loads into the output shifter.
  - The MSB is driven on the next sclk falling edge, and sdo_oe goes high.
  - Each subsequent falling edge shifts out one bit.
  - sdo_oe drops when the state leaves DATA.
  - sdio data bits are ignored.
- io_update rising edge: all registers are copied, active ← buffer, in one cycle, and upd_pulse is asserted.
- frame_err: pulses if IDLE is forced from INSTR or DATA with at least 1 bit received. The partial frame is discarded with no buffer change.

## Timing
- Reset values: sdo 0, sdo_oe 0, wr_valid 0, wr_addr 0, wr_data 0, upd_pulse 0, frame_err 0, act_data 0, both banks all-zero, FSM IDLE.
- Pin-to-edge latency: SYNC_STAGES+1 clk cycles from a pin transition to the detected edge.
- wr_valid: asserted the cycle after the detected 40th rising edge.
- sdo: valid SYNC_STAGES+2 clk cycles after the pin-level sclk falling edge.
  - This is why SCLK ≤ clk/8 is required: the master sees a stable bit before the next rising edge.
- Simultaneous io_update copy and write commit in the same cycle: the copy uses buffer contents from before the commit. The new value reaches the active bank on the next update.
- Reset mid-frame: everything returns to the reset values listed above; no frame_err is asserted.

## Configuration
- DDS_RSP_READBACK_EN defined: read frames operate as described above.
- DDS_RSP_READBACK_EN undefined:
  - Read instructions are decoded and the frame is consumed, but no data is returned.
  - sdo and sdo_oe are tied to 0, and the output shifter is removed.
  - Write, update and act_data behaviour are unchanged.

## Structure
- Package dds_spi_pkg holds:
  - the FSM state enum (IDLE, INSTR, DATA, DONE);
  - INSTR_W=8, DATA_W=32, ADDR_W=5;
  - the READ_BIT index 7.
- Sub-module spi_sync_edge: an N-stage synchronizer with rise and fall pulses. It is instantiated for each of sclk and io_update; cs, sdio and syncio use only its level output.
- Register banks and FSM are in the top module.

## Test plan
- Write frame instr 0x0E, data 0x12345678 → wr_valid pulse, wr_addr=0x0E, wr_data=0x12345678; act_data at 0x0E still 0 → io_update → upd_pulse, act_data=0x12345678.
- After the above, read frame instr 0x8E → sdo shifts 0x12345678 MSB-first with sdo_oe high during 32 bits. Without the macro, sdo and sdo_oe stay 0 throughout.
- Write 0x01 with data 0xDEADBEEF, cs raised after 20 bits → frame_err pulse, no wr_valid, buffer[0x01] unchanged (verified by io_update + act_data=0).
- syncio pulsed at bit 12, then a full write 0x02/0xA5A5A5A5 → frame_err once, then a correct commit of 0xA5A5A5A5 to 0x02.
- io_update edge in the same cycle as a write commit to 0x03 (0x55AA55AA) → act_data(0x03)=old value; after a second io_update → 0x55AA55AA.
- rst asserted at bit 30 of a write → all outputs zero, both banks zero, next frame decodes correctly.
